config_chain_driver: RTL and testbench

Host-side driver for the serial configuration shift-register chain. It takes a parallel CHAIN_LEN-bit configuration image and shifts it MSB-first into the chain on a divided shift clock. It then issues the one-period load strobe that transfers the chain into its output latches. While shifting, it captures the chain's previous contents from the chain's serial output and checks them against the last image it wrote. It sits between the control-register/slow-control logic and the chain's Clk/Serial_in/Load/Serial_Out pins.

---
 rtl/config_chain_driver_pkg.sv | 10 +
 rtl/config_chain_driver_sclk.sv | 51 +++++
 rtl/config_chain_driver.sv | 188 ++++++++++++++++++
 tb/tb_config_chain_driver.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/config_chain_driver_pkg.sv
// Shared types for the serial configuration chain driver.
package config_chain_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LOAD  = 2'd2
    } state_e;

endpackage

// File: rtl/config_chain_driver_sclk.sv
// cfg_sclk_gen: divided shift-clock generator with rise/fall strobes.
// While run_i is low the clock is parked low and the phase counter is cleared.
module cfg_sclk_gen #(
    parameter int DIV = 1
) (
    input  logic Clk,
    input  logic rst_n,
    input  logic run_i,
    output logic sclk_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int PW = $clog2(DIV) + 1;
    localparam logic [PW-1:0] PH_LAST = PW'(DIV - 1);

    logic [PW-1:0] ph_q, ph_d;
    logic          sclk_q, sclk_d;
    logic          wrap_s;

    // Phase counting; the strobes fire on the cycle whose edge toggles sclk.
    always_comb begin
        wrap_s = run_i && (ph_q == PH_LAST);
        rise_o = wrap_s && !sclk_q;
        fall_o = wrap_s && sclk_q;
        if (!run_i) begin
            ph_d   = '0;
            sclk_d = 1'b0;
        end else if (wrap_s) begin
            ph_d   = '0;
            sclk_d = !sclk_q;
        end else begin
            ph_d   = ph_q + PW'(1);
            sclk_d = sclk_q;
        end
    end

    // Phase and clock registers.
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_q   <= '0;
            sclk_q <= 1'b0;
        end else begin
            ph_q   <= ph_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk_o = sclk_q;

endmodule

// File: rtl/config_chain_driver.sv
// Shifts a parallel image MSB-first into the configuration chain, strobes Load,
// and compares the captured old chain contents with the previously written image.
module config_chain_driver
    import config_chain_driver_pkg::*;
#(
    parameter int CHAIN_LEN = 16,
    parameter int DIV       = 1
) (
    input  logic                 Clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] cfg_data,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] rb_data,
    output logic                 rb_valid,
    output logic                 cfg_err,
    output logic                 sr_clk,
    output logic                 sr_sdo,
    output logic                 sr_load,
    input  logic                 sr_sdi
);

    localparam int CW = $clog2(CHAIN_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CHAIN_LEN - 1);

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [CHAIN_LEN-1:0] tx_q, tx_d, img_q, img_d, rbs_q, rbs_d;
    logic [CHAIN_LEN-1:0] rbd_q, rbd_d, last_q, last_d;
    logic                 busy_q, busy_d, done_q, done_d, rbv_q, rbv_d;
    logic                 err_q, err_d, sdo_q, sdo_d, load_q, load_d;
    logic                 first_q, first_d;
    logic                 run_s, rise_s, fall_s;

    assign run_s = (state_q != ST_IDLE);

    cfg_sclk_gen #(.DIV(DIV)) u_sclk (
        .Clk    (Clk),
        .rst_n  (rst_n),
        .run_i  (run_s),
        .sclk_o (sr_clk),
        .rise_o (rise_s),
        .fall_o (fall_s)
    );

    // State register.
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; periods end on the falling strobe.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_SHIFT;
                else       state_d = ST_IDLE;
            end
            ST_SHIFT: begin
                if (fall_s && (cnt_q == CNT_LAST)) state_d = ST_LOAD;
                else                               state_d = ST_SHIFT;
            end
            ST_LOAD: begin
                if (fall_s) state_d = ST_IDLE;
                else        state_d = ST_LOAD;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        cnt_d   = cnt_q;
        tx_d    = tx_q;
        img_d   = img_q;
        rbs_d   = rbs_q;
        rbd_d   = rbd_q;
        last_d  = last_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        rbv_d   = rbv_q;
        err_d   = err_q;
        sdo_d   = sdo_q;
        load_d  = load_q;
        first_d = first_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    tx_d   = cfg_data;
                    img_d  = cfg_data;
                    cnt_d  = '0;
                    rbs_d  = '0;
                    sdo_d  = cfg_data[CHAIN_LEN-1];
                    busy_d = 1'b1;
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_SHIFT: begin
                // Sample before the chain's own edge so the old bit is captured.
                if (rise_s) begin
                    rbs_d = {rbs_q[CHAIN_LEN-2:0], sr_sdi};
                end else begin
                    rbs_d = rbs_q;
                end
                if (fall_s) begin
                    tx_d  = tx_q << 1;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        sdo_d  = 1'b0;
                        load_d = 1'b1;
                    end else begin
                        sdo_d  = tx_q[CHAIN_LEN-2];
                        load_d = 1'b0;
                    end
                end else begin
                    tx_d = tx_q;
                end
            end
            ST_LOAD: begin
                if (fall_s) begin
                    load_d  = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    rbd_d   = rbs_q;
                    rbv_d   = 1'b1;
                    // Chain should hold the last image shifted once by its Load edge.
                    err_d   = first_q && (rbs_q != {last_q[CHAIN_LEN-2:0], 1'b0});
                    last_d  = img_q;
                    first_d = 1'b1;
                end else begin
                    load_d = 1'b1;
                end
            end
            default: begin
                busy_d = 1'b0;
                load_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            tx_q    <= '0;
            img_q   <= '0;
            rbs_q   <= '0;
            rbd_q   <= '0;
            last_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rbv_q   <= 1'b0;
            err_q   <= 1'b0;
            sdo_q   <= 1'b0;
            load_q  <= 1'b0;
            first_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            img_q   <= img_d;
            rbs_q   <= rbs_d;
            rbd_q   <= rbd_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rbv_q   <= rbv_d;
            err_q   <= err_d;
            sdo_q   <= sdo_d;
            load_q  <= load_d;
            first_q <= first_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rb_data  = rbd_q;
    assign rb_valid = rbv_q;
    assign cfg_err  = err_q;
    assign sr_sdo   = sdo_q;
    assign sr_load  = load_q;

endmodule

// File: tb/tb_config_chain_driver.sv
// Bench: two drivers (DIV=1 and DIV=3) on 4-bit behavioural chains; per-cycle pin
// timing from arithmetic, readback/error from an image-level chain model.
module tb_config_chain_driver;

    localparam int N = 4;
    localparam logic [N-1:0] MASK = 4'hF;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic         rst_n;
    logic         start [2];
    logic [N-1:0] cfg   [2];
    wire  [1:0]   busy, done, rb_valid, cfg_err, sr_clk, sr_sdo, sr_load, sr_sdi;
    wire  [N-1:0] rb_data [2];

    logic [N-1:0] chain_m [2] = '{default: 4'h0};
    logic [N-1:0] latch_m [2] = '{default: 4'h0};
    logic         stuck   [2];

    assign sr_sdi[0] = chain_m[0][N-1] | stuck[0];
    assign sr_sdi[1] = chain_m[1][N-1] | stuck[1];

    always @(posedge sr_clk[0]) begin
        if (sr_load[0]) latch_m[0] <= chain_m[0];
        chain_m[0] <= {chain_m[0][N-2:0], sr_sdo[0]};
    end
    always @(posedge sr_clk[1]) begin
        if (sr_load[1]) latch_m[1] <= chain_m[1];
        chain_m[1] <= {chain_m[1][N-2:0], sr_sdo[1]};
    end

    config_chain_driver #(.CHAIN_LEN(N), .DIV(1)) u_dut0 (
        .Clk(Clk), .rst_n(rst_n), .start(start[0]), .cfg_data(cfg[0]),
        .busy(busy[0]), .done(done[0]), .rb_data(rb_data[0]), .rb_valid(rb_valid[0]),
        .cfg_err(cfg_err[0]), .sr_clk(sr_clk[0]), .sr_sdo(sr_sdo[0]),
        .sr_load(sr_load[0]), .sr_sdi(sr_sdi[0]));

    config_chain_driver #(.CHAIN_LEN(N), .DIV(3)) u_dut1 (
        .Clk(Clk), .rst_n(rst_n), .start(start[1]), .cfg_data(cfg[1]),
        .busy(busy[1]), .done(done[1]), .rb_data(rb_data[1]), .rb_valid(rb_valid[1]),
        .cfg_err(cfg_err[1]), .sr_clk(sr_clk[1]), .sr_sdo(sr_sdo[1]),
        .sr_load(sr_load[1]), .sr_sdi(sr_sdi[1]));

    int n_chk = 0;
    int n_err = 0;

    // Reference state: old chain contents, last completed image, first-done flag.
    logic [N-1:0] ref_chain [2];
    logic [N-1:0] ref_last  [2];
    logic [N-1:0] ref_latch [2];
    bit           ref_first [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pins(input int u);
        return 32'({busy[u], done[u], sr_clk[u], sr_sdo[u], sr_load[u]});
    endfunction

    function automatic logic [31:0] outs(input int u);
        return 32'({busy[u], done[u], rb_valid[u], cfg_err[u], sr_clk[u], sr_sdo[u],
                    sr_load[u], rb_data[u]});
    endfunction

    task automatic xfer(input int u, input logic [N-1:0] img, input int abort_at,
                        output logic [N-1:0] o_rb, output logic o_err,
                        output logic [N-1:0] m_rb, output logic m_err);
        int div, per, tot, s;
        logic [4:0] exp;
        div = (u == 0) ? 1 : 3;
        per = 2 * div;
        tot = per * (N + 1);
        o_rb = '0; o_err = 1'b0; m_rb = '0; m_err = 1'b0;
        @(negedge Clk);
        check($sformatf("idle_before_start u%0d", u), 32'(busy[u]), 32'd0);
        cfg[u]   = img;
        start[u] = 1'b1;
        @(posedge Clk);
        #1;
        start[u] = 1'b0;
        for (int c = 0; c <= tot; c++) begin
            if (c > 0) begin
                @(posedge Clk);
                #1;
            end
            exp = {c < tot, c == tot, (c < tot) && ((c % per) >= div),
                   (c < per * N) ? img[N-1-c/per] : 1'b0,
                   (c >= per * N) && (c < tot)};
            check($sformatf("pins u%0d c%0d", u, c), pins(u), 32'(exp));
            // Start pulse and image change while busy must be ignored.
            if (c == 2) begin
                start[u] = 1'b1;
                cfg[u]   = ~img;
            end
            if (c == 3) start[u] = 1'b0;
            if (abort_at > 0 && c == abort_at) begin
                rst_n = 1'b0;
                #1;
                check("abort_outs u0", outs(0), 32'd0);
                check("abort_outs u1", outs(1), 32'd0);
                check("abort_latch", 32'(latch_m[u]), 32'(ref_latch[u]));
                s = (abort_at >= div) ? (abort_at - div) / per + 1 : 0;
                ref_chain[u] = ((ref_chain[u] << s) | (img >> (N - s))) & MASK;
                for (int k = 0; k < 2; k++) begin
                    ref_first[k] = 1'b0;
                    ref_last[k]  = '0;
                end
                @(negedge Clk);
                rst_n = 1'b1;
                return;
            end
        end
        m_rb  = stuck[u] ? MASK : ref_chain[u];
        m_err = ref_first[u] && (m_rb != ((ref_last[u] << 1) & MASK));
        o_rb  = rb_data[u];
        o_err = cfg_err[u];
        check($sformatf("latch u%0d", u), 32'(latch_m[u]), 32'(img));
        check($sformatf("rb_valid u%0d", u), 32'(rb_valid[u]), 32'd1);
        ref_chain[u] = (img << 1) & MASK;
        ref_last[u]  = img;
        ref_latch[u] = img;
        ref_first[u] = 1'b1;
    endtask

    typedef struct {
        int           u;
        logic [N-1:0] img;
        bit           stk;
        int           abort;
        logic [N-1:0] exp_rb;
        logic         exp_err;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] o_rb, m_rb, img;
        logic         o_err, m_err;
        int           u;

        tbl[0] = '{0, 4'b1011, 1'b0, 0, 4'b0000, 1'b0};
        tbl[1] = '{0, 4'b0110, 1'b0, 0, 4'b0110, 1'b0};
        tbl[2] = '{0, 4'b1111, 1'b1, 0, 4'b1111, 1'b1};
        tbl[3] = '{0, 4'b0001, 1'b0, 0, 4'b1110, 1'b0};
        tbl[4] = '{0, 4'b1000, 1'b0, 0, 4'b0010, 1'b0};
        tbl[5] = '{1, 4'b1011, 1'b0, 0, 4'b0000, 1'b0};
        tbl[6] = '{1, 4'b0101, 1'b0, 0, 4'b0110, 1'b0};
        tbl[7] = '{0, 4'b0111, 1'b0, 4, 4'b0000, 1'b0};
        tbl[8] = '{0, 4'b1100, 1'b0, 0, 4'b0001, 1'b0};
        tbl[9] = '{0, 4'b0011, 1'b0, 0, 4'b1000, 1'b0};

        for (int k = 0; k < 2; k++) begin
            start[k]     = 1'b0;
            cfg[k]       = '0;
            stuck[k]     = 1'b0;
            ref_chain[k] = '0;
            ref_last[k]  = '0;
            ref_latch[k] = '0;
            ref_first[k] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check("reset_outs u0", outs(0), 32'd0);
        check("reset_outs u1", outs(1), 32'd0);
        @(negedge Clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            stuck[tbl[i].u] = tbl[i].stk;
            xfer(tbl[i].u, tbl[i].img, tbl[i].abort, o_rb, o_err, m_rb, m_err);
            stuck[tbl[i].u] = 1'b0;
            if (tbl[i].abort == 0) begin
                check($sformatf("tbl%0d rb_data", i), 32'(o_rb), 32'(tbl[i].exp_rb));
                check($sformatf("tbl%0d cfg_err", i), 32'(o_err), 32'(tbl[i].exp_err));
            end
        end

        for (int i = 0; i < 16; i++) begin
            u   = int'($urandom_range(0, 1));
            img = N'($urandom);
            stuck[u] = ($urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 2)) @(posedge Clk);
            xfer(u, img, 0, o_rb, o_err, m_rb, m_err);
            stuck[u] = 1'b0;
            check($sformatf("rnd%0d rb_data", i), 32'(o_rb), 32'(m_rb));
            check($sformatf("rnd%0d cfg_err", i), 32'(o_err), 32'(m_err));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
